// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives 2**N_IN vectors, dwells DWELL cycles, samples f_in.
// Optional build macro TT_CHECK_EN adds a comparison of the final table against expected_tt.
module truth_table_sweeper #(
  parameter int N_IN  = 4,
  parameter int DWELL = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 f_in,
`ifdef TT_CHECK_EN
  input  logic [2**N_IN-1:0]   expected_tt,
  output logic                 pass,
  output logic                 fail,
`endif
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 table_valid
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [7:0]      DWELL_LAST = 8'(DWELL - 1);
  localparam logic [N_IN-1:0] VEC_LAST   = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE    = N_IN'(1);

  state_t              state, state_nxt;
  logic [7:0]          dwell_cnt, cnt_nxt;
  logic [N_IN-1:0]     vec_nxt;
  logic [2**N_IN-1:0]  tbl_nxt;
  logic                valid_nxt;
`ifdef TT_CHECK_EN
  logic                pass_nxt, fail_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = dwell_cnt;
    vec_nxt   = vec_out;
    tbl_nxt   = table_out;
    valid_nxt = table_valid;
`ifdef TT_CHECK_EN
    pass_nxt  = pass;
    fail_nxt  = fail;
`endif
    case (state)
      IDLE: begin
        // abort has priority over a simultaneous start
        if (start && !abort) begin
          state_nxt = DRIVE;
          vec_nxt   = '0;
          cnt_nxt   = '0;
          valid_nxt = 1'b0;
`ifdef TT_CHECK_EN
          pass_nxt  = 1'b0;
          fail_nxt  = 1'b0;
`endif
        end
      end
      DRIVE: begin
        if (abort) begin
          state_nxt = IDLE;
          vec_nxt   = '0;
          cnt_nxt   = '0;
        end else if (dwell_cnt == DWELL_LAST) begin
          state_nxt = SAMPLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = dwell_cnt + 8'd1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_nxt = IDLE;
          vec_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
          tbl_nxt[vec_out] = f_in;
          if (vec_out == VEC_LAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = DRIVE;
            vec_nxt   = vec_out + VEC_ONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        vec_nxt   = '0;
        valid_nxt = 1'b1;
`ifdef TT_CHECK_EN
        pass_nxt  = (table_out == expected_tt);
        fail_nxt  = (table_out != expected_tt);
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dwell_cnt   <= '0;
      vec_out     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      table_out   <= '0;
      table_valid <= 1'b0;
`ifdef TT_CHECK_EN
      pass        <= 1'b0;
      fail        <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      dwell_cnt   <= cnt_nxt;
      vec_out     <= vec_nxt;
      busy        <= (state_nxt == DRIVE) || (state_nxt == SAMPLE);
      done        <= (state_nxt == DONE);
      table_out   <= tbl_nxt;
      table_valid <= valid_nxt;
`ifdef TT_CHECK_EN
      pass        <= pass_nxt;
      fail        <= fail_nxt;
`endif
    end
  end

endmodule
